// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the 2-read/1-write register file.
// Entry count, address width and the hardwired-zero index.
package regfile_2r1w_pkg;

  localparam int REGFILE_NREGS = 32;
  localparam int REGFILE_AW    = 5;
  localparam int ZERO_REG      = 0;

endpackage

// File: rtl/regfile_2r1w_read_port.sv
// One registered read port: address mux, write forwarding,
// zero-register override, rd_data/rd_valid output flops.
// Ports: clk, reset (async active-low), rd_en/rd_addr in,
//   regs (whole array), wr_en/wr_addr/wr_data for forwarding,
//   rd_data/rd_valid out.
module regfile_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int n     = 32,
  parameter int NREGS = REGFILE_NREGS,
  parameter int AW    = REGFILE_AW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  input  logic [NREGS-1:0][n-1:0]   regs,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [n-1:0]              wr_data,
  output logic [n-1:0]              rd_data,
  output logic                      rd_valid
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [n-1:0] data_d, data_q;
  logic         valid_d, valid_q;
  logic         is_zero;
  logic         is_fwd;

  // Zero and forward are exclusive: forwarding needs wr_addr != 0.
  assign is_zero = (rd_addr == ZA);
  assign is_fwd  = wr_en && (wr_addr != ZA)
                && (rd_addr == wr_addr);

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (rd_en) begin
      valid_d = 1'b1;
      unique case (1'b1)
        is_zero: data_d = '0;
        is_fwd:  data_d = wr_data;
        default: data_d = regs[rd_addr];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_data  = data_q;
  assign rd_valid = valid_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, NREGS x n bits, one write port, two
// registered read ports with forwarding; entry 0 reads zero.
// Ports: clk, reset (async active-low), wr_en/wr_addr/wr_data,
//   rd_en_x/rd_addr_x in, rd_data_x/rd_valid_x out (x = a, b).
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int n     = 32,
  parameter int NREGS = REGFILE_NREGS,
  parameter int AW    = REGFILE_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [n-1:0]  wr_data,
  input  logic          rd_en_a,
  input  logic [AW-1:0] rd_addr_a,
  output logic [n-1:0]  rd_data_a,
  output logic          rd_valid_a,
  input  logic          rd_en_b,
  input  logic [AW-1:0] rd_addr_b,
  output logic [n-1:0]  rd_data_b,
  output logic          rd_valid_b
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [NREGS-1:0][n-1:0] entries_d, entries_q;

  // Entry 0 is never written, so it stays at its reset value.
  always_comb begin
    entries_d = entries_q;
    if (wr_en && (wr_addr != ZA)) begin
      entries_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  regfile_read_port #(
    .n     (n),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .regs     (entries_q),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  regfile_read_port #(
    .n     (n),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .regs     (entries_q),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed + random bench for regfile_2r1w against an
// array-based model of the register file behaviour.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en_a;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic        rd_valid_a;
  logic        rd_en_b;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        rd_valid_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_da, exp_db;
  logic        exp_va, exp_vb;

  regfile_2r1w dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_valid_a (rd_valid_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .rd_valid_b (rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(
      input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    exp_da = 0; exp_db = 0;
    exp_va = 0; exp_vb = 0;
  endtask

  // Predict the edge from current inputs, clock, then check.
  task automatic cycle(input string tag);
    if (!reset) begin
      model_clear();
    end else begin
      exp_va = rd_en_a;
      exp_vb = rd_en_b;
      if (rd_en_a) exp_da = model_rd(rd_addr_a);
      if (rd_en_b) exp_db = model_rd(rd_addr_b);
      if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    chk({tag, "_da"}, rd_data_a, exp_da);
    chk({tag, "_va"}, 32'(rd_valid_a), 32'(exp_va));
    chk({tag, "_db"}, rd_data_b, exp_db);
    chk({tag, "_vb"}, 32'(rd_valid_b), 32'(exp_vb));
  endtask

  task automatic idle();
    wr_en = 0; rd_en_a = 0; rd_en_b = 0;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic rda(input logic [4:0] a);
    rd_en_a = 1; rd_addr_a = a;
  endtask

  task automatic rdb(input logic [4:0] a);
    rd_en_b = 1; rd_addr_b = a;
  endtask

  initial begin
    reset = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en_a = 0; rd_addr_a = 0;
    rd_en_b = 0; rd_addr_b = 0;
    model_clear();

    // Reset held for 3 cycles
    repeat (3) cycle("rst");
    reset = 1;

    // Reads after reset
    rda(0); rdb(0);   cycle("r0");
    rda(5); rdb(5);   cycle("r5");
    rda(31); rdb(31); cycle("r31");
    idle();           cycle("ridle");

    // Basic write then read
    wr(7, 32'hDEADBEEF); cycle("w7");
    idle(); rda(7);      cycle("rd7");
    chk("basic_data", rd_data_a, 32'hDEADBEEF);
    idle();              cycle("hold7");
    chk("basic_hold", rd_data_a, 32'hDEADBEEF);
    chk("basic_vlow", 32'(rd_valid_a), 32'h0);

    // Forwarding on port B
    wr(12, 32'hAAAA5555); cycle("w12");
    wr(12, 32'h12345678); rdb(12); cycle("fwd12");
    chk("fwd_b", rd_data_b, 32'h12345678);
    idle(); rdb(12);      cycle("rd12");

    // Zero register
    wr(0, 32'hFFFFFFFF); rda(0); cycle("z_fwd");
    chk("zero_a", rd_data_a, 32'h0);
    idle(); rdb(0);      cycle("z_rd");
    chk("zero_b", rd_data_b, 32'h0);

    // Dual port
    idle(); wr(3, 32'h11); cycle("w3");
    idle(); wr(4, 32'h22); cycle("w4");
    idle(); rda(3); rdb(4); cycle("dual1");
    chk("dual1_a", rd_data_a, 32'h11);
    chk("dual1_b", rd_data_b, 32'h22);
    rda(4); rdb(4);         cycle("dual2");
    chk("dual2_a", rd_data_a, 32'h22);
    chk("dual2_b", rd_data_b, 32'h22);

    // Both ports forward the same write
    idle(); wr(9, 32'hCAFEF00D); rda(9); rdb(9);
    cycle("fwd_both");

    // Async reset mid-stream
    idle(); rda(7); rdb(4); cycle("pre_rst");
    idle();
    #2;
    reset = 0;
    #1;
    model_clear();
    chk("arst_da", rd_data_a, 32'h0);
    chk("arst_va", 32'(rd_valid_a), 32'h0);
    chk("arst_db", rd_data_b, 32'h0);
    chk("arst_vb", 32'(rd_valid_b), 32'h0);
    cycle("arst_hold");
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      rda(5'(i)); rdb(5'(31 - i));
      cycle("post_rst");
    end
    idle(); cycle("post_idle");

    // Random traffic, biased toward forwarding hits
    for (int i = 0; i < 400; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_en_a = 1'($urandom_range(0, 3) != 0);
      rd_en_b = 1'($urandom_range(0, 3) != 0);
      rd_addr_a = ($urandom_range(0, 3) == 0)
                ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0)
                ? wr_addr : 5'($urandom_range(0, 31));
      cycle("rand");
    end
    idle(); cycle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Register file of NREGS n-bit entries with one write port and two independently enabled read ports.
- Read data is registered, so it appears one cycle after the request.
- Same-cycle write-to-read forwarding is built in, and entry 0 always reads as zero.
- Sits between the datapath's operand-fetch stage and the 32-bit adder/ALU; the datapath's n-bit register writers are the other end.

Parameters:
- n, 32, data width of each entry.
- NREGS, 32, number of entries; must be a power of two, at least 2.
- AW, 5, address width; must equal log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all entries and read outputs.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write address.
- wr_data  input  n  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  AW  read address, port A.
- rd_data_a  output  n  registered read data, port A.
- rd_valid_a  output  1  high for one cycle when rd_data_a holds a new result.
- rd_en_b  input  1  read request, port B.
- rd_addr_b  input  AW  read address, port B.
- rd_data_b  output  n  registered read data, port B.
- rd_valid_b  output  1  high for one cycle when rd_data_b holds a new result.

Behaviour:
- Reset low (asynchronous), regardless of clk:
  - all entries = 0.
  - rd_data_a = rd_data_b = 0.
  - rd_valid_a = rd_valid_b = 0.
- Reset release: takes effect on the first rising edge with reset high.
- Reset asserted mid-operation: any pending read result is discarded; valids drop immediately.
- Write: on an edge with wr_en=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
  - Writes to address 0 are ignored; entry 0 stays 0 permanently.
- Read latency is exactly 1 cycle. On an edge with rd_en_x=1:
  - rd_data_x <= value of entry[rd_addr_x] as seen in that cycle.
  - rd_valid_x <= 1.
- On an edge with rd_en_x=0:
  - rd_valid_x <= 0.
  - rd_data_x holds its previous value (no change).
- Forwarding: if rd_en_x=1, wr_en=1, rd_addr_x==wr_addr and wr_addr!=0 in the same cycle, rd_data_x <= wr_data (the new value, not the old entry).
- Address 0 read: always returns 0, even when a write to address 0 is in the same cycle.
- Simultaneous reads:
  - Ports A and B are fully independent.
  - Both may read the same address in one cycle and both receive identical data.
  - Both ports forward when both match wr_addr.
- No stalls or back-pressure; one request per port per cycle, back-to-back reads sustained indefinitely.
- Addresses are fully decoded; no out-of-range case exists because NREGS = 2^AW.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package holds:
  - REGFILE_NREGS (32).
  - REGFILE_AW (5).
  - ZERO_REG (0), hardwired-zero index.
- One natural sub-module: regfile_read_port, instantiated twice. It contains:
  - the address mux;
  - the forwarding compare;
  - the zero-register override;
  - the rd_data/rd_valid output registers.
- Storage array and write decode stay in the top module.

Test Plan:
- Reset: hold reset low 3 cycles, then read addresses 0, 5 and 31 on both ports -> each returns 0x00000000 with valid high for exactly one cycle after each request.
- Basic write/read: write 0xDEADBEEF to addr 7; next cycle read addr 7 on port A -> rd_data_a=0xDEADBEEF and rd_valid_a=1 one cycle later; the following idle cycle gives rd_valid_a=0 with data held.
- Forwarding: same cycle, wr_en=1, wr_addr=12, wr_data=0x12345678 and rd_en_b=1, rd_addr_b=12 (old value 0xAAAA5555) -> rd_data_b=0x12345678.
- Zero register: write 0xFFFFFFFF to addr 0, with a simultaneous forwarding-case read of addr 0 on port A and a later read on port B -> both return 0.
- Dual port: preload addr 3=0x11 and addr 4=0x22; in one cycle read A=3, B=4, then A=4, B=4 -> outputs (0x11, 0x22), then (0x22, 0x22), valids high both cycles.
- Async reset mid-stream: a read is issued, then reset is pulled low between edges -> rd_data and rd_valid go to 0 immediately without a clock edge; afterwards all entries read 0.
